// File: rtl/router_mc_top.sv
// Multi-channel packet router: framed byte stream in, one FWFT FIFO per output
// channel, parity/length checking, invalid-address drop, per-channel read timeout.
module router_mc_top #(
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 30
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       pkt_valid,
    input  logic [DATA_W-1:0]          data_in,
    input  logic [NUM_CH-1:0]          read_enb,
    output logic [NUM_CH*DATA_W-1:0]   data_out,
    output logic [NUM_CH-1:0]          valid_out,
    output logic                       busy,
    output logic                       error
);

    localparam int unsigned ADDR_W = ($clog2(NUM_CH) > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CH_PAD = 32'd1 << ADDR_W;
    localparam int unsigned LEN_W  = DATA_W - ADDR_W;
    localparam int unsigned CNT_W  = LEN_W + 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;
    localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_CHECK = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   dest, dest_nxt, wr_ch;
    logic [LEN_W-1:0]    len_q, len_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [DATA_W-1:0]   par, par_nxt;
    logic                err_nxt;
    logic                wr_en;

    logic [ADDR_W-1:0]   hdr_addr;
    logic [LEN_W-1:0]    hdr_len;
    logic                addr_ok;

    logic [NUM_CH-1:0]   full, pop, flush, push;
    logic [CH_PAD-1:0]   full_pad, flush_pad;

    logic [DATA_W-1:0]   mem    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]    wr_ptr [NUM_CH];
    logic [PTR_W-1:0]    rd_ptr [NUM_CH];
    logic [FCNT_W-1:0]   fcount [NUM_CH];
    logic [TMR_W-1:0]    timer  [NUM_CH];

    // Header field split; address range check widened so NUM_CH never truncates
    assign hdr_addr  = data_in[ADDR_W-1:0];
    assign hdr_len   = data_in[DATA_W-1:ADDR_W];
    assign addr_ok   = {1'b0, hdr_addr} < (ADDR_W + 1)'(NUM_CH);
    assign full_pad  = CH_PAD'(full);
    assign flush_pad = CH_PAD'(flush);

    // Per-channel status, pop/flush decode and FWFT head output
    always_comb begin
        full      = '0;
        pop       = '0;
        flush     = '0;
        valid_out = '0;
        data_out  = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            valid_out[i] = (fcount[i] != '0);
            full[i]      = (fcount[i] == FCNT_W'(DEPTH));
            pop[i]       = read_enb[i] & valid_out[i];
            flush[i]     = valid_out[i] & ~read_enb[i] & (timer[i] == TMR_W'(TIMEOUT - 1));
            if (valid_out[i]) begin
                data_out[i*DATA_W +: DATA_W] = mem[i][rd_ptr[i]];
            end
        end
    end

    // Framing FSM: next state, busy, FIFO write request and packet bookkeeping
    always_comb begin
        state_nxt = state;
        dest_nxt  = dest;
        len_nxt   = len_q;
        cnt_nxt   = cnt;
        par_nxt   = par;
        err_nxt   = error;
        busy      = 1'b0;
        wr_en     = 1'b0;
        wr_ch     = dest;
        case (state)
            S_IDLE: begin
                wr_ch = hdr_addr;
                if (pkt_valid) begin
                    if (!addr_ok) begin
                        err_nxt   = 1'b0;
                        state_nxt = S_DROP;
                    end else if (full_pad[hdr_addr]) begin
                        busy = 1'b1;
                    end else begin
                        wr_en     = 1'b1;
                        dest_nxt  = hdr_addr;
                        len_nxt   = hdr_len;
                        par_nxt   = data_in;
                        cnt_nxt   = '0;
                        err_nxt   = 1'b0;
                        // a header lost to a same-cycle flush makes the packet useless
                        state_nxt = flush_pad[hdr_addr] ? S_DROP : S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (full_pad[dest]) begin
                    busy = 1'b1;
                    if (flush_pad[dest]) begin
                        state_nxt = S_DROP;
                    end
                end else begin
                    wr_en   = 1'b1;
                    par_nxt = par ^ data_in;
                    if (pkt_valid) begin
                        cnt_nxt = (cnt == '1) ? cnt : cnt + 1'b1;
                        if (flush_pad[dest]) begin
                            state_nxt = S_DROP;
                        end
                    end else if (flush_pad[dest]) begin
                        // parity beat lost to the flush: packet ends bad right here
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_CHECK;
                    end
                end
            end
            S_CHECK: begin
                busy      = 1'b1;
                err_nxt   = (par != '0) || (cnt != CNT_W'(len_q));
                state_nxt = S_IDLE;
            end
            S_DROP: begin
                if (!pkt_valid) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Write strobe per channel; a flush wins over a same-cycle write
    always_comb begin
        push = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            push[i] = wr_en & (wr_ch == ADDR_W'(i)) & ~flush[i];
        end
    end

    // FSM and packet registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            dest  <= '0;
            len_q <= '0;
            cnt   <= '0;
            par   <= '0;
            error <= 1'b0;
        end else begin
            state <= state_nxt;
            dest  <= dest_nxt;
            len_q <= len_nxt;
            cnt   <= cnt_nxt;
            par   <= par_nxt;
            error <= err_nxt;
        end
    end

    // FIFO pointers, occupancy and read-timeout timers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                fcount[i] <= '0;
                timer[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (flush[i]) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                    fcount[i] <= '0;
                    timer[i]  <= '0;
                end else begin
                    if (push[i]) begin
                        wr_ptr[i] <= wr_ptr[i] + 1'b1;
                    end
                    if (pop[i]) begin
                        rd_ptr[i] <= rd_ptr[i] + 1'b1;
                    end
                    if (push[i] && !pop[i]) begin
                        fcount[i] <= fcount[i] + 1'b1;
                    end else if (!push[i] && pop[i]) begin
                        fcount[i] <= fcount[i] - 1'b1;
                    end
                    if (!valid_out[i] || pop[i]) begin
                        timer[i] <= '0;
                    end else begin
                        timer[i] <= timer[i] + 1'b1;
                    end
                end
            end
        end
    end

    // FIFO storage; contents only observable while the channel is non-empty
    always_ff @(posedge clock) begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= data_in;
            end
        end
    end

endmodule

// File: tb/tb_router_mc_top.sv
// Bench for router_mc_top: directed scenarios plus randomized packets, every
// cycle compared against a queue-based packet model.
module tb_router_mc_top;

    localparam int NUM_CH  = 3;
    localparam int DATA_W  = 8;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 30;

    logic        clock = 1'b0;
    logic        resetn;
    logic        pkt_valid;
    logic [7:0]  data_in;
    logic [2:0]  read_enb;
    logic [23:0] data_out;
    logic [2:0]  valid_out;
    logic        busy;
    logic        error;

    router_mc_top #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .pkt_valid(pkt_valid),
        .data_in  (data_in),
        .read_enb (read_enb),
        .data_out (data_out),
        .valid_out(valid_out),
        .busy     (busy),
        .error    (error)
    );

    always #5 clock = ~clock;

    int vectors     = 0;
    int miscompares = 0;
    int rd_pct      = 0;

    // Reference model: channel contents as queues plus packet progress flags
    logic [7:0] mq [NUM_CH][$];
    int         mtmr [NUM_CH];
    bit         m_in_pkt, m_discard, m_verdict, m_err;
    int         m_dest, m_len, m_cnt;
    logic [7:0] m_par;
    logic [7:0] pay_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            mq[i].delete();
            mtmr[i] = 0;
        end
        m_in_pkt = 0; m_discard = 0; m_verdict = 0; m_err = 0;
        m_dest = 0; m_len = 0; m_cnt = 0; m_par = 8'h00;
    endfunction

    function automatic bit model_busy(input logic pv, input logic [7:0] d);
        int a;
        a = int'(d[1:0]);
        if (m_verdict) return 1'b1;
        if (!m_in_pkt) begin
            if (!pv || a >= NUM_CH) return 1'b0;
            return mq[a].size() == DEPTH;
        end
        if (m_discard) return 1'b0;
        return mq[m_dest].size() == DEPTH;
    endfunction

    function automatic logic [2:0] exp_valid();
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) r[i] = (mq[i].size() != 0);
        return r;
    endfunction

    function automatic logic [23:0] exp_data();
        logic [23:0] r;
        r = '0;
        for (int i = 0; i < NUM_CH; i++) if (mq[i].size() != 0) r[i*8 +: 8] = mq[i][0];
        return r;
    endfunction

    // Advance the model by one clock given this cycle's inputs
    function automatic void model_step(input logic pv, input logic [7:0] d, input logic [2:0] rd);
        bit pop [NUM_CH];
        bit fl  [NUM_CH];
        int sz  [NUM_CH];
        int wr;
        int a;
        wr = -1;
        a  = int'(d[1:0]);
        for (int i = 0; i < NUM_CH; i++) begin
            sz[i]  = mq[i].size();
            pop[i] = rd[i] && sz[i] > 0;
            fl[i]  = sz[i] > 0 && !pop[i] && mtmr[i] == TIMEOUT - 1;
        end
        if (m_verdict) begin
            m_err     = (m_par != 8'h00) || (m_cnt != m_len);
            m_verdict = 0;
        end else if (!m_in_pkt) begin
            if (pv) begin
                if (a >= NUM_CH) begin
                    m_err = 0; m_in_pkt = 1; m_discard = 1;
                end else if (sz[a] < DEPTH) begin
                    wr = a; m_err = 0; m_dest = a; m_len = int'(d[7:2]);
                    m_par = d; m_cnt = 0; m_in_pkt = 1; m_discard = fl[a];
                end
            end
        end else if (m_discard) begin
            if (!pv) begin
                m_err = 1; m_in_pkt = 0; m_discard = 0;
            end
        end else if (sz[m_dest] == DEPTH) begin
            if (fl[m_dest]) m_discard = 1;
        end else begin
            wr    = m_dest;
            m_par = m_par ^ d;
            if (pv) begin
                m_cnt++;
                if (fl[m_dest]) m_discard = 1;
            end else begin
                m_in_pkt = 0;
                if (fl[m_dest]) m_err = 1;
                else m_verdict = 1;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (fl[i]) begin
                mq[i].delete();
                mtmr[i] = 0;
            end else begin
                if (pop[i]) void'(mq[i].pop_front());
                if (wr == i) mq[i].push_back(d);
                mtmr[i] = (sz[i] > 0 && !pop[i]) ? mtmr[i] + 1 : 0;
            end
        end
    endfunction

    function automatic logic [2:0] rd_gen();
        logic [2:0] r;
        for (int i = 0; i < NUM_CH; i++) r[i] = ($urandom_range(0, 99) < rd_pct);
        return r;
    endfunction

    // One clock: drive at negedge, compare all outputs, then advance the model
    task automatic step(input logic pv, input logic [7:0] d, input logic [2:0] rd, output bit acc);
        bit eb;
        @(negedge clock);
        pkt_valid = pv;
        data_in   = d;
        read_enb  = rd;
        #1;
        eb = model_busy(pv, d);
        chk("busy",      32'(busy),      32'(eb));
        chk("error",     32'(error),     32'(m_err));
        chk("valid_out", 32'(valid_out), 32'(exp_valid()));
        chk("data_out",  32'(data_out),  32'(exp_data()));
        acc = !eb;
        model_step(pv, d, rd);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) step(1'b0, 8'h00, rd_gen(), acc);
    endtask

    task automatic drain();
        bit acc;
        for (int k = 0; k < 40; k++) step(1'b0, 8'h00, 3'b111, acc);
    endtask

    // Send header, pay_q payload and parity (optionally corrupted), honouring busy
    task automatic send_pkt(input int a, input int l, input logic [7:0] flip);
        logic [8:0] bq [$];
        logic [7:0] h, p;
        bit acc;
        int n;
        h = 8'((l << 2) | a);
        p = h;
        bq.push_back({1'b1, h});
        foreach (pay_q[k]) begin
            p = p ^ pay_q[k];
            bq.push_back({1'b1, pay_q[k]});
        end
        bq.push_back({1'b0, p ^ flip});
        foreach (bq[k]) begin
            n   = 0;
            acc = 0;
            while (!acc && n < 400) begin
                step(bq[k][8], bq[k][7:0], rd_gen(), acc);
                n++;
            end
            chk("accept", 32'(acc), 32'd1);
        end
    endtask

    initial begin
        bit         acc, done, v0;
        int         n, n2, a, l, m, npay;
        logic [7:0] exp1 [5];
        logic [7:0] pv_k, d_k;

        resetn    = 1'b0;
        pkt_valid = 1'b0;
        data_in   = 8'h00;
        read_enb  = 3'b000;
        model_reset();
        repeat (2) @(negedge clock);
        #1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_data",  32'(data_out),  32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_error", 32'(error),     32'd0);
        resetn = 1'b1;

        // 1: good packet to ch1, read back in order
        rd_pct = 0;
        pay_q = '{8'hA1, 8'h52, 8'h3C};
        send_pkt(1, 3, 8'h00);
        idle(2);
        chk("t1_error", 32'(error), 32'd0);
        chk("t1_ch0",   32'(valid_out[0]), 32'd0);
        chk("t1_ch2",   32'(valid_out[2]), 32'd0);
        exp1[0] = 8'h0D; exp1[1] = 8'hA1; exp1[2] = 8'h52; exp1[3] = 8'h3C;
        exp1[4] = 8'h0D ^ 8'hA1 ^ 8'h52 ^ 8'h3C;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 8'h00, 3'b010, acc);
            chk("t1_data", 32'(data_out[15:8]), 32'(exp1[k]));
        end
        step(1'b0, 8'h00, 3'b000, acc);
        chk("t1_empty", 32'(valid_out[1]), 32'd0);

        // 2: bad parity still stores 5 beats and flags error until next header
        send_pkt(1, 3, 8'h01);
        idle(2);
        chk("t2_error", 32'(error), 32'd1);
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 8'h00, 3'b010, acc);
            if (valid_out[1]) n++;
        end
        chk("t2_count", 32'(n), 32'd5);
        pay_q.delete();
        send_pkt(1, 0, 8'h00);
        chk("t2_clear", 32'(error), 32'd0);
        drain();

        // 3: address 3 is dropped without backpressure
        pkt_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            pv_k = (k < 3) ? 8'h01 : 8'h00;
            d_k  = (k == 0) ? 8'h0B : (k == 1) ? 8'h11 : (k == 2) ? 8'h22 : 8'h3A;
            step(pv_k[0], d_k, 3'b000, acc);
            chk("t3_busy", 32'(busy), 32'd0);
        end
        step(1'b0, 8'h00, 3'b000, acc);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_valid", 32'(valid_out), 32'd0);

        // 4: full ch0 holds the next header until one entry is read
        pay_q.delete();
        for (int k = 0; k < 14; k++) pay_q.push_back(8'($urandom));
        send_pkt(0, 14, 8'h00);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'h00, 3'b000, acc);
            chk("t4_busy", 32'(busy), 32'd1);
            chk("t4_head", 32'(data_out[7:0]), 32'h38);
        end
        step(1'b1, 8'h00, 3'b001, acc);
        chk("t4_busy_rd", 32'(busy), 32'd1);
        step(1'b1, 8'h00, 3'b000, acc);
        chk("t4_accept", 32'(busy), 32'd0);
        n = 0; acc = 0;
        while (!acc && n < 50) begin
            step(1'b0, 8'h00, 3'b001, acc);
            n++;
        end
        chk("t4_parity", 32'(acc), 32'd1);
        drain();

        // 5: unread ch2 flushed after 30 valid cycles, ch0 left alone
        n2 = 0; done = 0; v0 = 0;
        for (int k = 0; k < 40; k++) begin
            pv_k = (k == 0 || k == 3) ? 8'h01 : 8'h00;
            d_k  = (k == 0 || k == 1) ? 8'h02 : 8'h00;
            step(pv_k[0], d_k, 3'b000, acc);
            if (valid_out[2]) n2++;
            else if (n2 > 0 && !done) begin
                done = 1;
                v0   = valid_out[0];
            end
        end
        chk("t5_valid_cycles", 32'(n2), 32'd30);
        chk("t5_ch0_kept",     32'(v0), 32'd1);

        // 6: reset in the middle of a packet, then route a fresh one
        step(1'b1, 8'h0D, 3'b000, acc);
        step(1'b1, 8'hA1, 3'b000, acc);
        @(negedge clock);
        resetn    = 1'b0;
        pkt_valid = 1'b0;
        #1;
        chk("t6_valid", 32'(valid_out), 32'd0);
        chk("t6_data",  32'(data_out),  32'd0);
        chk("t6_busy",  32'(busy),      32'd0);
        chk("t6_error", 32'(error),     32'd0);
        model_reset();
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        pay_q = '{8'hA1, 8'h52, 8'h3C};
        send_pkt(1, 3, 8'h00);
        idle(2);
        chk("t6_route", 32'(data_out[15:8]), 32'h0D);
        chk("t6_ok",    32'(error), 32'd0);
        drain();

        // Random traffic: frequent reads, then sparse reads for full/timeout cases
        for (int phase = 0; phase < 2; phase++) begin
            rd_pct = (phase == 0) ? 75 : 5;
            for (int p = 0; p < 60; p++) begin
                a = $urandom_range(0, 3);
                l = $urandom_range(0, 12);
                m = $urandom_range(0, 9);
                npay = l;
                if (m == 0) npay = l + 1;
                else if (m == 1 && l > 0) npay = l - 1;
                pay_q.delete();
                for (int k = 0; k < npay; k++) pay_q.push_back(8'($urandom));
                send_pkt(a, l, (m == 2) ? 8'($urandom_range(1, 255)) : 8'h00);
                idle($urandom_range(0, 2));
            end
            drain();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
